adc_touch_ctrl: RTL and testbench

- Sequencer for the touch-panel serial ADC.
- Detects pen-down on PENIRQ_n and debounces it.
- Runs 80-step X/Y conversion frames: drives CS_n and DCLK, and supplies trans_en/count_80 to the existing DIN generator.
- Deserialises DOUT into 12-bit X/Y coordinates, publishes them with a one-cycle strobe, and repeats frames while the pen stays down.

---
 rtl/adc_touch_ctrl_pkg.sv | 36 +++
 rtl/adc_touch_ctrl_tick_gen.sv | 48 ++++
 rtl/adc_touch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_adc_touch_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_touch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_touch_pkg
// Description : Shared types and constants for the touch-panel ADC sequencer:
//               FSM state encoding, frame length, DOUT sample windows and
//               coordinate width.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_touch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_TRANS    = 3'd2,
    ST_UPDATE   = 3'd3,
    ST_GAP      = 3'd4
  } state_e;

  localparam int FRAME_STEPS = 80;
  localparam int STEP_W      = 7;
  localparam int COORD_W     = 12;

  // DCLK rising-edge steps (odd values) on which DOUT carries coordinate bits
  localparam int X_FIRST = 19;
  localparam int X_LAST  = 41;
  localparam int Y_FIRST = 51;
  localparam int Y_LAST  = 73;

  // True when an odd step lies inside the inclusive window [first, last]
  function automatic logic in_window(input logic [STEP_W-1:0] step,
                                     input int first, input int last);
    return step[0] && (step >= STEP_W'(first)) && (step <= STEP_W'(last));
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_touch_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : adc_tick_gen
// Description : DCLK half-period prescaler plus the mod-80 frame step counter
//               that feeds count_80. Clear has priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_tick_gen
  import adc_touch_pkg::*;
#(
  parameter int DIV_HALF = 25
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              en_i,
  input  logic              clr_i,
  output logic              tick_o,
  output logic [STEP_W-1:0] count_o
);

  localparam int PW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

  logic [PW-1:0]     presc_q;
  logic [STEP_W-1:0] count_q;

  assign tick_o  = en_i && !clr_i && (presc_q == PW'(DIV_HALF - 1));
  assign count_o = count_q;

  // Prescaler wraps every DIV_HALF cycles; the step counter advances on each wrap
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      presc_q <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      presc_q <= '0;
      count_q <= '0;
    end else if (en_i) begin
      if (tick_o) begin
        presc_q <= '0;
        count_q <= (count_q == STEP_W'(FRAME_STEPS - 1)) ? '0 : count_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_touch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_touch_ctrl
// Description : Touch-panel serial ADC sequencer. Debounces pen-down, runs
//               80-step X/Y conversion frames, deserialises DOUT into 12-bit
//               coordinates and repeats frames while the pen stays down.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_touch_ctrl
  import adc_touch_pkg::*;
#(
  parameter int DIV_HALF   = 25,
  parameter int DEB_CYCLES = 50000,
  parameter int GAP_CYCLES = 25000
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic               iEN,
  input  logic               iADC_PENIRQ_n,
  input  logic               iADC_DOUT,
  output logic               oADC_CS_n,
  output logic               oADC_DCLK,
  output logic               trans_en,
  output logic [STEP_W-1:0]  count_80,
  output logic [COORD_W-1:0] oX_COORD,
  output logic [COORD_W-1:0] oY_COORD,
  output logic               oNEW_COORD,
  output logic               oBUSY
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e             state_q;
  logic [DEB_W-1:0]   deb_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               cs_n_q, trans_en_q, new_q, busy_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COORD_W-1:0] xsh_q, xsh_d, ysh_q, ysh_d;
  logic               pen_meta_q, pen_s_q, dout_meta_q, dout_s_q;
  logic               tick;
  logic [STEP_W-1:0]  step_next;

  adc_tick_gen #(.DIV_HALF(DIV_HALF)) u_tick_gen (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .en_i    (state_q == ST_TRANS),
    .clr_i   (state_q != ST_TRANS),
    .tick_o  (tick),
    .count_o (count_80)
  );

  // DCLK follows the step parity; count_80 is held at 0 outside TRANS
  assign oADC_DCLK  = count_80[0];
  assign oADC_CS_n  = cs_n_q;
  assign trans_en   = trans_en_q;
  assign oNEW_COORD = new_q;
  assign oBUSY      = busy_q;
  assign oX_COORD   = x_q;
  assign oY_COORD   = y_q;
  assign step_next  = count_80 + 1'b1;

  // Two-flop synchronisers for the asynchronous ADC inputs
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pen_meta_q  <= 1'b1;
      pen_s_q     <= 1'b1;
      dout_meta_q <= 1'b0;
      dout_s_q    <= 1'b0;
    end else begin
      pen_meta_q  <= iADC_PENIRQ_n;
      pen_s_q     <= pen_meta_q;
      dout_meta_q <= iADC_DOUT;
      dout_s_q    <= dout_meta_q;
    end
  end

  // Shift DOUT in on DCLK rising edges that fall inside the X or Y window
  always_comb begin
    xsh_d = xsh_q;
    ysh_d = ysh_q;
    if (state_q != ST_TRANS) begin
      xsh_d = '0;
      ysh_d = '0;
    end else if (tick && !count_80[0]) begin
      if (in_window(step_next, X_FIRST, X_LAST)) xsh_d = {xsh_q[COORD_W-2:0], dout_s_q};
      if (in_window(step_next, Y_FIRST, Y_LAST)) ysh_d = {ysh_q[COORD_W-2:0], dout_s_q};
    end
  end

  // Shift registers; cleared whenever not converting so each frame starts at 0
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      xsh_q <= '0;
      ysh_q <= '0;
    end else begin
      xsh_q <= xsh_d;
      ysh_q <= ysh_d;
    end
  end

  // Frame sequencer with registered outputs updated on each state transition
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= ST_IDLE;
      deb_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      cs_n_q     <= 1'b1;
      trans_en_q <= 1'b0;
      new_q      <= 1'b0;
      busy_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      new_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iEN && !pen_s_q) begin
            state_q   <= ST_DEBOUNCE;
            deb_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (pen_s_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
            state_q    <= ST_TRANS;
            cs_n_q     <= 1'b0;
            trans_en_q <= 1'b1;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        ST_TRANS: begin
          // PENIRQ toggles during conversion, so the pen is not watched here
          if (tick && (count_80 == STEP_W'(FRAME_STEPS - 1))) begin
            state_q    <= ST_UPDATE;
            cs_n_q     <= 1'b1;
            trans_en_q <= 1'b0;
            new_q      <= 1'b1;
            x_q        <= xsh_q;
            y_q        <= ysh_q;
          end
        end
        ST_UPDATE: begin
          state_q   <= ST_GAP;
          gap_cnt_q <= '0;
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
            if (iEN && !pen_s_q) begin
              state_q    <= ST_TRANS;
              cs_n_q     <= 1'b0;
              trans_en_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          cs_n_q     <= 1'b1;
          trans_en_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_touch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_touch_ctrl
// Description : Self-checking bench for adc_touch_ctrl with a behavioural
//               serial ADC model and a coordinate scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_touch_ctrl;

  localparam int DIV = 2;
  localparam int DEB = 8;
  localparam int GAP = 4;
  localparam int FRAME_CYC = 80 * DIV;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b1;
  logic        iEN = 1'b0;
  logic        iADC_PENIRQ_n = 1'b1;
  logic        iADC_DOUT = 1'b0;
  logic        oADC_CS_n, oADC_DCLK, trans_en, oNEW_COORD, oBUSY;
  logic [6:0]  count_80;
  logic [11:0] oX_COORD, oY_COORD;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] exp_q[$];
  logic [11:0] model_x = '0;
  logic [11:0] model_y = '0;

  int cyc = 0, cs_low = 0, dclk_rise = 0, strobes = 0;
  logic dclk_prev = 1'b0;

  always #5 iCLK = ~iCLK;

  adc_touch_ctrl #(.DIV_HALF(DIV), .DEB_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
    .iCLK          (iCLK),
    .iRST_n        (iRST_n),
    .iEN           (iEN),
    .iADC_PENIRQ_n (iADC_PENIRQ_n),
    .iADC_DOUT     (iADC_DOUT),
    .oADC_CS_n     (oADC_CS_n),
    .oADC_DCLK     (oADC_DCLK),
    .trans_en      (trans_en),
    .count_80      (count_80),
    .oX_COORD      (oX_COORD),
    .oY_COORD      (oY_COORD),
    .oNEW_COORD    (oNEW_COORD),
    .oBUSY         (oBUSY)
  );

  // ADC model: while DCLK is high on step c, present the bit sampled at step c+2
  function automatic logic model_bit(input logic [6:0] c, input logic [11:0] mx,
                                     input logic [11:0] my);
    int s;
    s = int'(c) + 2;
    if (s >= 19 && s <= 41) return mx[11 - (s - 19) / 2];
    if (s >= 51 && s <= 73) return my[11 - (s - 51) / 2];
    return 1'($urandom_range(1, 0));
  endfunction

  always @(negedge iCLK) begin
    if (!oADC_CS_n && count_80[0]) iADC_DOUT <= model_bit(count_80, model_x, model_y);
  end

  // Activity counters
  always @(negedge iCLK) begin
    cyc       <= cyc + 1;
    dclk_prev <= oADC_DCLK;
    if (!oADC_CS_n) cs_low <= cs_low + 1;
    if (oADC_DCLK && !dclk_prev) dclk_rise <= dclk_rise + 1;
    if (oNEW_COORD) strobes <= strobes + 1;
  end

  task automatic wait_strobe(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge iCLK);
      if (oNEW_COORD) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_step(input logic [6:0] step, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge iCLK);
      if (!oADC_CS_n && count_80 == step) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int s0, c0;
    @(negedge iCLK);
    iRST_n = 1'b0;
    repeat (3) @(negedge iCLK);
    n_cmp++; if (oADC_CS_n !== 1'b1) begin n_err++; $display("FAIL rst_cs_n got=%b exp=1", oADC_CS_n); end
    n_cmp++; if ({oADC_DCLK, trans_en, oNEW_COORD, oBUSY} !== 4'b0) begin n_err++; $display("FAIL rst_ctl got=%b exp=0000", {oADC_DCLK, trans_en, oNEW_COORD, oBUSY}); end
    n_cmp++; if ({count_80, oX_COORD, oY_COORD} !== 31'd0) begin n_err++; $display("FAIL rst_data got=%h exp=0", {count_80, oX_COORD, oY_COORD}); end
    iRST_n = 1'b1;
    iEN = 1'b1;
    s0 = strobes; c0 = cs_low;
    repeat (100) @(negedge iCLK);
    n_cmp++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b exp=0", oBUSY); end
    n_cmp++; if (cs_low - c0 !== 0) begin n_err++; $display("FAIL idle_cs got=%0d exp=0", cs_low - c0); end
    n_cmp++; if (strobes - s0 !== 0) begin n_err++; $display("FAIL idle_strobe got=%0d exp=0", strobes - s0); end
    n_cmp++; if ({oADC_DCLK, trans_en} !== 2'b00) begin n_err++; $display("FAIL idle_dclk_trans got=%b exp=00", {oADC_DCLK, trans_en}); end
  endtask

  task automatic test_debounce_abort();
    int c0;
    bit seen_busy;
    c0 = cs_low;
    seen_busy = 1'b0;
    iADC_PENIRQ_n = 1'b0;
    repeat (5) begin @(negedge iCLK); seen_busy |= oBUSY; end
    iADC_PENIRQ_n = 1'b1;
    repeat (12) @(negedge iCLK);
    n_cmp++; if (seen_busy !== 1'b1) begin n_err++; $display("FAIL deb_busy_seen got=%b exp=1", seen_busy); end
    n_cmp++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL deb_back_idle got=%b exp=0", oBUSY); end
    n_cmp++; if (cs_low - c0 !== 0) begin n_err++; $display("FAIL deb_cs got=%0d exp=0", cs_low - c0); end
  endtask

  task automatic test_single_frame();
    int c0, r0;
    bit ok;
    logic [23:0] e;
    model_x = 12'hA5C; model_y = 12'h3F1;
    exp_q.push_back({model_x, model_y});
    c0 = cs_low; r0 = dclk_rise;
    iADC_PENIRQ_n = 1'b0;
    wait_strobe(1000, ok);
    iADC_PENIRQ_n = 1'b1;
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL single_strobe got=timeout exp=strobe"); exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      n_cmp++; if (oX_COORD !== e[23:12]) begin n_err++; $display("FAIL single_x got=%h exp=%h", oX_COORD, e[23:12]); end
      n_cmp++; if (oY_COORD !== e[11:0]) begin n_err++; $display("FAIL single_y got=%h exp=%h", oY_COORD, e[11:0]); end
      n_cmp++; if (cs_low - c0 !== FRAME_CYC) begin n_err++; $display("FAIL single_cs_len got=%0d exp=%0d", cs_low - c0, FRAME_CYC); end
      n_cmp++; if (dclk_rise - r0 !== 40) begin n_err++; $display("FAIL single_dclk got=%0d exp=40", dclk_rise - r0); end
      @(negedge iCLK);
      n_cmp++; if (oNEW_COORD !== 1'b0) begin n_err++; $display("FAIL single_strobe_width got=%b exp=0", oNEW_COORD); end
    end
    repeat (GAP + 6) @(negedge iCLK);
    n_cmp++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL single_idle got=%b exp=0", oBUSY); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vx[3] = '{12'h123, 12'hFED, 12'h5A0};
    logic [11:0] vy[3] = '{12'h876, 12'h00F, 12'hC3C};
    int t_prev, s0;
    bit ok;
    logic [23:0] e;
    for (int k = 0; k < 3; k++) exp_q.push_back({vx[k], vy[k]});
    model_x = vx[0]; model_y = vy[0];
    s0 = strobes; t_prev = 0;
    iADC_PENIRQ_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(1000, ok);
      if (k == 2) iADC_PENIRQ_n = 1'b1;
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL b2b_strobe%0d got=timeout exp=strobe", k);
        break;
      end
      e = exp_q.pop_front();
      n_cmp++; if ({oX_COORD, oY_COORD} !== e) begin n_err++; $display("FAIL b2b_xy%0d got=%h exp=%h", k, {oX_COORD, oY_COORD}, e); end
      if (k > 0) begin
        n_cmp++; if (cyc - t_prev !== FRAME_CYC + 1 + GAP) begin n_err++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", k, cyc - t_prev, FRAME_CYC + 1 + GAP); end
      end
      t_prev = cyc;
      if (k < 2) begin model_x = vx[k+1]; model_y = vy[k+1]; end
    end
    iADC_PENIRQ_n = 1'b1;
    exp_q.delete();
    repeat (GAP + 6) @(negedge iCLK);
    n_cmp++; if (strobes - s0 !== 3) begin n_err++; $display("FAIL b2b_count got=%0d exp=3", strobes - s0); end
    n_cmp++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b exp=0", oBUSY); end
  endtask

  task automatic test_pen_lift();
    int c0;
    bit ok;
    logic [23:0] e;
    model_x = 12'h7E1; model_y = 12'h19B;
    exp_q.push_back({model_x, model_y});
    iADC_PENIRQ_n = 1'b0;
    wait_step(7'd30, 1000, ok);
    iADC_PENIRQ_n = 1'b1;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL lift_reach30 got=timeout exp=step30"); end
    wait_strobe(500, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL lift_strobe got=timeout exp=strobe"); exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      n_cmp++; if ({oX_COORD, oY_COORD} !== e) begin n_err++; $display("FAIL lift_xy got=%h exp=%h", {oX_COORD, oY_COORD}, e); end
    end
    repeat (GAP + 4) @(negedge iCLK);
    n_cmp++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL lift_idle got=%b exp=0", oBUSY); end
    c0 = cs_low;
    repeat (50) @(negedge iCLK);
    n_cmp++; if (cs_low - c0 !== 0) begin n_err++; $display("FAIL lift_no_frame got=%0d exp=0", cs_low - c0); end
  endtask

  task automatic test_enable_drop();
    int c0;
    bit ok;
    logic [23:0] e;
    model_x = 12'h4C7; model_y = 12'hB28;
    exp_q.push_back({model_x, model_y});
    iADC_PENIRQ_n = 1'b0;
    wait_step(7'd30, 1000, ok);
    iEN = 1'b0;
    wait_strobe(500, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL endrop_strobe got=timeout exp=strobe"); exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      n_cmp++; if ({oX_COORD, oY_COORD} !== e) begin n_err++; $display("FAIL endrop_xy got=%h exp=%h", {oX_COORD, oY_COORD}, e); end
    end
    repeat (GAP + 4) @(negedge iCLK);
    c0 = cs_low;
    repeat (50) @(negedge iCLK);
    n_cmp++; if ({oBUSY, 32'(cs_low - c0)} !== 33'd0) begin n_err++; $display("FAIL endrop_idle busy=%b cs=%0d exp=0/0", oBUSY, cs_low - c0); end
    iADC_PENIRQ_n = 1'b1;
    repeat (4) @(negedge iCLK);
    iEN = 1'b1;
  endtask

  task automatic test_async_reset();
    int s0;
    bit ok;
    model_x = 12'hFFF; model_y = 12'hFFF;
    iADC_PENIRQ_n = 1'b0;
    wait_step(7'd45, 1000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL arst_reach45 got=timeout exp=step45"); end
    #2 iRST_n = 1'b0;
    #1;
    n_cmp++; if (oADC_CS_n !== 1'b1) begin n_err++; $display("FAIL arst_cs_n got=%b exp=1", oADC_CS_n); end
    n_cmp++; if ({oADC_DCLK, trans_en, oNEW_COORD, oBUSY} !== 4'b0) begin n_err++; $display("FAIL arst_ctl got=%b exp=0000", {oADC_DCLK, trans_en, oNEW_COORD, oBUSY}); end
    n_cmp++; if ({count_80, oX_COORD, oY_COORD} !== 31'd0) begin n_err++; $display("FAIL arst_data got=%h exp=0", {count_80, oX_COORD, oY_COORD}); end
    iADC_PENIRQ_n = 1'b1;
    s0 = strobes;
    repeat (3) @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (300) @(negedge iCLK);
    n_cmp++; if (strobes - s0 !== 0) begin n_err++; $display("FAIL arst_no_strobe got=%0d exp=0", strobes - s0); end
    n_cmp++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL arst_idle got=%b exp=0", oBUSY); end
  endtask

  initial begin
    test_reset();
    test_debounce_abort();
    test_single_frame();
    test_back_to_back();
    test_pen_lift();
    test_enable_drop();
    test_async_reset();
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
